// File: rtl/axi_write_arbiter_if.sv
// Bundled requester-side and slave-side write channels (AW, W, B) of the arbiter.
// "master" is the arbiter's view; "slave" is the view of the surrounding masters and slave.
interface axi_write_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned ADDR_W      = 33,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned DATA_W      = 8
);
  logic [NUM_MASTERS-1:0]        m_awvalid;
  logic [NUM_MASTERS-1:0]        m_awready;
  logic [NUM_MASTERS*ID_W-1:0]   m_awid;
  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr;
  logic [NUM_MASTERS*LEN_W-1:0]  m_awlen;
  logic [NUM_MASTERS-1:0]        m_wvalid;
  logic [NUM_MASTERS-1:0]        m_wready;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_wlast;
  logic [NUM_MASTERS-1:0]        m_bvalid;
  logic [NUM_MASTERS-1:0]        m_bready;
  logic [ID_W-1:0]               m_bid;
  logic [1:0]                    m_bresp;

  logic                          s_awvalid;
  logic                          s_awready;
  logic [ID_W-1:0]               s_awid;
  logic [ADDR_W-1:0]             s_awaddr;
  logic [LEN_W-1:0]              s_awlen;
  logic                          s_wvalid;
  logic                          s_wready;
  logic [DATA_W-1:0]             s_wdata;
  logic                          s_wlast;
  logic                          s_bvalid;
  logic                          s_bready;
  logic [ID_W-1:0]               s_bid;
  logic [1:0]                    s_bresp;

  modport master (
    input  m_awvalid, m_awid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
    output m_awready, m_wready, m_bvalid, m_bid, m_bresp,
    output s_awvalid, s_awid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wlast, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bid, s_bresp
  );

  modport slave (
    output m_awvalid, m_awid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
    input  m_awready, m_wready, m_bvalid, m_bid, m_bresp,
    input  s_awvalid, s_awid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wlast, s_bready,
    output s_awready, s_wready, s_bvalid, s_bid, s_bresp
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter granting one complete AXI write (AW, W beats, B) at a time
// to one of NUM_MASTERS requesters; WLAST towards the slave comes from a beat counter.
module axi_write_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned ADDR_W      = 33,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned DATA_W      = 8,
  localparam int unsigned G          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_write_arbiter_if.master  bus,
  output logic [G-1:0]         grant,
  output logic                 busy,
  output logic                 wlast_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t           state_q, state_d;
  logic [G-1:0]     grant_q, grant_d;
  logic [G-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0] beats_q, beats_d;

  logic              g_awvalid, g_wvalid, g_wlast, g_bready;
  logic [ID_W-1:0]   g_awid;
  logic [ADDR_W-1:0] g_awaddr;
  logic [LEN_W-1:0]  g_awlen;
  logic [DATA_W-1:0] g_wdata;
  logic              aw_hs, w_hs, b_hs, last_beat;
  logic              scan_hit;
  int unsigned       scan_idx;

  assign g_awvalid = bus.m_awvalid[grant_q];
  assign g_wvalid  = bus.m_wvalid[grant_q];
  assign g_wlast   = bus.m_wlast[grant_q];
  assign g_bready  = bus.m_bready[grant_q];
  assign g_awid    = bus.m_awid[grant_q*ID_W +: ID_W];
  assign g_awaddr  = bus.m_awaddr[grant_q*ADDR_W +: ADDR_W];
  assign g_awlen   = bus.m_awlen[grant_q*LEN_W +: LEN_W];
  assign g_wdata   = bus.m_wdata[grant_q*DATA_W +: DATA_W];

  assign last_beat = (beats_q == '0);
  assign aw_hs     = (state_q == ADDR) && g_awvalid && bus.s_awready;
  assign w_hs      = (state_q == DATA) && g_wvalid && bus.s_wready;
  assign b_hs      = (state_q == RESP) && bus.s_bvalid && g_bready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beats_q  <= beats_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beats_d  = beats_q;
    scan_hit = 1'b0;
    scan_idx = 0;
    case (state_q)
      IDLE: begin
        // Rotating-priority scan starting at rr_ptr, wrapping without a modulo operator.
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          scan_idx = int'(rr_ptr_q) + i;
          if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
          if (!scan_hit && bus.m_awvalid[scan_idx]) begin
            scan_hit = 1'b1;
            grant_d  = G'(scan_idx);
          end
        end
        if (scan_hit) state_d = ADDR;
      end
      ADDR: begin
        if (aw_hs) begin
          beats_d = g_awlen;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (last_beat) state_d = RESP;
          else           beats_d = beats_q - 1'b1;
        end
      end
      RESP: begin
        if (b_hs) begin
          rr_ptr_d = (grant_q == G'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.m_bvalid  = '0;
    bus.m_bid     = '0;
    bus.m_bresp   = '0;
    bus.s_awvalid = 1'b0;
    bus.s_awid    = '0;
    bus.s_awaddr  = '0;
    bus.s_awlen   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wlast   = 1'b0;
    bus.s_bready  = 1'b0;
    wlast_err     = 1'b0;
    case (state_q)
      ADDR: begin
        bus.s_awvalid          = g_awvalid;
        bus.s_awid             = g_awid;
        bus.s_awaddr           = g_awaddr;
        bus.s_awlen            = g_awlen;
        bus.m_awready[grant_q] = bus.s_awready;
      end
      DATA: begin
        bus.s_wvalid          = g_wvalid;
        bus.s_wdata           = g_wdata;
        bus.s_wlast           = last_beat;
        bus.m_wready[grant_q] = bus.s_wready;
        wlast_err             = w_hs && (g_wlast != last_beat);
      end
      RESP: begin
        bus.m_bvalid[grant_q] = bus.s_bvalid;
        bus.m_bid             = bus.s_bvalid ? bus.s_bid : '0;
        bus.m_bresp           = bus.s_bvalid ? bus.s_bresp : '0;
        bus.s_bready          = g_bready;
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: single burst, round-robin, backpressure,
// WLAST mismatch, response routing and mid-burst reset.
module tb_axi_write_arbiter;
  localparam int N  = 4;
  localparam int IW = 6;
  localparam int AW = 33;
  localparam int LW = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       busy;
  logic       wlast_err;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         busy_cnt = 0;
  int         exp_g [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  axi_write_arbiter_if #(.NUM_MASTERS(N), .ID_W(IW), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) bus ();

  axi_write_arbiter #(.NUM_MASTERS(N), .ID_W(IW), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .wlast_err (wlast_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                    input logic [LW-1:0] len);
    bus.m_awid[m*IW +: IW]   = id;
    bus.m_awaddr[m*AW +: AW] = addr;
    bus.m_awlen[m*LW +: LW]  = len;
  endtask

  task automatic wd(input int m, input logic [DW-1:0] d, input logic last);
    bus.m_wdata[m*DW +: DW] = d;
    bus.m_wlast[m]          = last;
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.m_awvalid = '0; bus.m_awid = '0; bus.m_awaddr = '0; bus.m_awlen = '0;
    bus.m_wvalid = '0; bus.m_wdata = '0; bus.m_wlast = '0; bus.m_bready = '0;
    bus.s_awready = 1'b1; bus.s_wready = 1'b1; bus.s_bvalid = 1'b0;
    bus.s_bid = '0; bus.s_bresp = '0;
    bus.m_awvalid = 4'b0001;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_s_awvalid", bus.s_awvalid, 0);
    chk("rst_m_awready", bus.m_awready, 0);
    chk("rst_s_wlast", bus.s_wlast, 0);
    chk("rst_s_bready", bus.s_bready, 0);
    chk("rst_wlast_err", wlast_err, 0);

    // Single master, AWLEN=3
    nx();
    reset = 1'b1;
    aw(0, 6'h05, 33'h1_0000_1000, 4'd3);
    bus.m_bready = 4'b0001;
    #1 chk("t1_idle_busy", busy, 0);
    nx();
    bus.m_wvalid = 4'b0001;
    wd(0, 8'h11, 1'b0);
    #1;
    chk("t1_s_awvalid", bus.s_awvalid, 1);
    chk("t1_s_awaddr", bus.s_awaddr, 33'h1_0000_1000);
    chk("t1_s_awid", bus.s_awid, 6'h05);
    chk("t1_s_awlen", bus.s_awlen, 3);
    chk("t1_m_awready", bus.m_awready, 4'b0001);
    chk("t1_s_wvalid_addr", bus.s_wvalid, 0);
    busy_cnt += int'(busy);
    for (int b = 0; b < 4; b++) begin
      nx();
      if (b == 0) bus.m_awvalid = '0;
      wd(0, 8'(8'h11 * (b + 1)), b == 3);
      #1;
      chk("t1_s_wdata", bus.s_wdata, 8'h11 * (b + 1));
      chk("t1_s_wlast", bus.s_wlast, (b == 3) ? 1 : 0);
      chk("t1_m_wready", bus.m_wready, 4'b0001);
      chk("t1_wlast_err", wlast_err, 0);
      busy_cnt += int'(busy);
    end
    nx();
    bus.m_wvalid = '0;
    #1;
    chk("t1_s_bready", bus.s_bready, 1);
    chk("t1_m_bvalid_wait", bus.m_bvalid, 0);
    busy_cnt += int'(busy);
    nx();
    bus.s_bvalid = 1'b1; bus.s_bid = 6'h05; bus.s_bresp = 2'b01;
    #1;
    chk("t1_m_bvalid", bus.m_bvalid, 4'b0001);
    chk("t1_m_bid", bus.m_bid, 6'h05);
    chk("t1_m_bresp", bus.m_bresp, 2'b01);
    busy_cnt += int'(busy);
    nx();
    bus.s_bvalid = 1'b0;
    #1;
    chk("t1_end_busy", busy, 0);
    chk("t1_end_m_bid", bus.m_bid, 0);
    chk("t1_busy_cycles", busy_cnt, 7);

    // Round-robin with all four requesting, AWLEN=0
    nx();
    reset = 1'b0;
    nx();
    reset = 1'b1;
    for (int m = 0; m < N; m++) aw(m, 6'(6'h10 + m), 33'(m * 16), 4'd0);
    bus.m_awvalid = 4'b1111; bus.m_wvalid = 4'b1111; bus.m_wlast = 4'b1111;
    bus.m_bready = 4'b1111; bus.s_bvalid = 1'b1; bus.s_bid = 6'h3F; bus.s_bresp = 2'b00;
    for (int k = 0; k < 5; k++) begin
      nx(); #1;
      chk("t2_grant", grant, exp_g[k]);
      chk("t2_s_awid", bus.s_awid, 6'h10 + exp_g[k]);
      chk("t2_s_awvalid", bus.s_awvalid, 1);
      nx(); #1;
      chk("t2_s_wlast", bus.s_wlast, 1);
      chk("t2_m_wready", bus.m_wready, 64'd1 << exp_g[k]);
      chk("t2_wlast_err", wlast_err, 0);
      nx(); #1;
      chk("t2_m_bvalid", bus.m_bvalid, 64'd1 << exp_g[k]);
      chk("t2_m_bid", bus.m_bid, 6'h3F);
      nx();
      if (k == 4) bus.m_awvalid = '0;
      #1 chk("t2_idle_busy", busy, 0);
    end

    // Backpressure on a 2-beat burst from master 1
    nx();
    bus.m_wvalid = 4'b0010; bus.m_wlast = '0; bus.s_bvalid = 1'b1; bus.m_bready = 4'b0010;
    aw(1, 6'h21, 33'h1_2345_6789, 4'd1);
    wd(1, 8'hA1, 1'b0);
    bus.m_awvalid = 4'b0010;
    #1 chk("t3_idle_busy", busy, 0);
    nx(); #1;
    chk("t3_grant", grant, 1);
    chk("t3_s_awlen", bus.s_awlen, 1);
    chk("t3_s_awaddr", bus.s_awaddr, 33'h1_2345_6789);
    chk("t3_m_awready", bus.m_awready, 4'b0010);
    nx();
    bus.m_awvalid = '0;
    #1;
    chk("t3_s_wdata0", bus.s_wdata, 8'hA1);
    chk("t3_s_wlast0", bus.s_wlast, 0);
    chk("t3_m_wready0", bus.m_wready, 4'b0010);
    nx();
    wd(1, 8'hB2, 1'b1); bus.s_wready = 1'b0;
    #1;
    chk("t3_m_wready_stall", bus.m_wready, 0);
    chk("t3_s_wdata_stall", bus.s_wdata, 8'hB2);
    chk("t3_s_wlast_stall", bus.s_wlast, 1);
    chk("t3_m_bvalid_data", bus.m_bvalid, 0);
    nx(); #1;
    chk("t3_s_wlast_hold", bus.s_wlast, 1);
    chk("t3_s_wvalid_hold", bus.s_wvalid, 1);
    nx();
    bus.s_wready = 1'b1;
    #1;
    chk("t3_m_wready1", bus.m_wready, 4'b0010);
    chk("t3_wlast_err", wlast_err, 0);
    nx();
    bus.m_wvalid = '0;
    #1 chk("t3_m_bvalid", bus.m_bvalid, 4'b0010);

    // Master 2: AWVALID drop in ADDR, early WLAST, stalled response
    nx();
    bus.m_bready = '0; bus.s_bvalid = 1'b0;
    aw(2, 6'h12, 33'h0_0000_0200, 4'd2);
    bus.m_awvalid = 4'b0100;
    #1;
    nx();
    bus.m_awvalid = '0;
    #1;
    chk("t4_grant_drop", grant, 2);
    chk("t4_s_awvalid_drop", bus.s_awvalid, 0);
    chk("t4_busy_drop", busy, 1);
    nx();
    bus.m_awvalid = 4'b0100; bus.m_wvalid = 4'b0100;
    wd(2, 8'hC1, 1'b1);
    #1;
    chk("t4_s_awvalid", bus.s_awvalid, 1);
    chk("t4_m_awready", bus.m_awready, 4'b0100);
    nx();
    bus.m_awvalid = '0;
    #1;
    chk("t4_err_beat1", wlast_err, 1);
    chk("t4_s_wlast1", bus.s_wlast, 0);
    chk("t4_s_wdata1", bus.s_wdata, 8'hC1);
    nx();
    wd(2, 8'hC2, 1'b0);
    #1;
    chk("t4_err_beat2", wlast_err, 0);
    chk("t4_s_wlast2", bus.s_wlast, 0);
    nx();
    wd(2, 8'hC3, 1'b1);
    #1;
    chk("t4_err_beat3", wlast_err, 0);
    chk("t4_s_wlast3", bus.s_wlast, 1);
    chk("t4_m_wready3", bus.m_wready, 4'b0100);
    nx();
    bus.m_wvalid = '0; bus.s_bvalid = 1'b1; bus.s_bid = 6'h2A; bus.s_bresp = 2'b10;
    bus.m_bready = 4'b1011;
    for (int r = 0; r < 3; r++) begin
      if (r > 0) nx();
      #1;
      chk("t5_m_bvalid", bus.m_bvalid, 4'b0100);
      chk("t5_m_bid", bus.m_bid, 6'h2A);
      chk("t5_m_bresp", bus.m_bresp, 2'b10);
      chk("t5_s_bready", bus.s_bready, 0);
      chk("t5_busy", busy, 1);
    end
    nx();
    bus.m_bready = 4'b1111;
    #1 chk("t5_s_bready_go", bus.s_bready, 1);
    nx();
    bus.s_bvalid = 1'b0;
    #1 chk("t5_idle_busy", busy, 0);

    // Reset in the middle of a master-3 burst
    aw(3, 6'h33, 33'h0_0000_0300, 4'd3);
    aw(0, 6'h01, 33'h0_0000_0010, 4'd0);
    bus.m_awvalid = 4'b1000; bus.m_wvalid = 4'b1000;
    wd(3, 8'hD1, 1'b0);
    nx(); #1;
    chk("t6_grant3", grant, 3);
    nx();
    bus.m_awvalid = '0;
    #1 chk("t6_s_wdata1", bus.s_wdata, 8'hD1);
    nx();
    wd(3, 8'hD2, 1'b0);
    #1 chk("t6_s_wvalid2", bus.s_wvalid, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_s_wvalid", bus.s_wvalid, 0);
    chk("t6_rst_m_wready", bus.m_wready, 0);
    chk("t6_rst_s_wlast", bus.s_wlast, 0);
    chk("t6_rst_s_awvalid", bus.s_awvalid, 0);
    nx();
    reset = 1'b1;
    bus.m_awvalid = 4'b1001; bus.m_wvalid = '0;
    #1 chk("t6_rel_busy", busy, 0);
    nx(); #1;
    chk("t6_grant0", grant, 0);
    chk("t6_s_awid", bus.s_awid, 6'h01);
    chk("t6_m_bvalid", bus.m_bvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Round-robin arbiter that shares one AXI-style write channel (AW, W, B) between `NUM_MASTERS` requesters. It sits in front of the write-channel interface and grants one complete write transaction at a time: address, then all data beats, then the write response. The response is routed back to the owning master before the next grant. A beat counter loaded from AWLEN drives WLAST towards the slave and checks each master's WLAST.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters (2–8).
- `ID_W`, 6: AWID/BID width.
- `ADDR_W`, 33: AWADDR width.
- `LEN_W`, 4: AWLEN width (beats = AWLEN+1).
- `DATA_W`, 8: WDATA width.

Ports (N = `NUM_MASTERS`, G = clog2(N); all per-master vectors are flat concatenations, master 0 in the LSBs):
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m_awvalid` in N, `m_awready` out N, `m_awid` in N*ID_W, `m_awaddr` in N*ADDR_W, `m_awlen` in N*LEN_W: per-master address channels.
- `m_wvalid` in N, `m_wready` out N, `m_wdata` in N*DATA_W, `m_wlast` in N: per-master data channels.
- `m_bvalid` out N, `m_bready` in N: per-master response handshake.
- `m_bid` out ID_W, `m_bresp` out 2: shared response payload, meaningful only where `m_bvalid` is high.
- `s_awvalid` out 1, `s_awready` in 1, `s_awid` out ID_W, `s_awaddr` out ADDR_W, `s_awlen` out LEN_W: slave address channel.
- `s_wvalid` out 1, `s_wready` in 1, `s_wdata` out DATA_W, `s_wlast` out 1: slave data channel.
- `s_bvalid` in 1, `s_bready` out 1, `s_bid` in ID_W, `s_bresp` in 2: slave response channel.
- `grant` out G: index of the current owner.
- `busy` out 1: high in any state other than IDLE.
- `wlast_err` out 1: one-cycle pulse on a WLAST mismatch.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registered state: `grant`, round-robin pointer `rr_ptr` (G bits), beat counter `beats` (LEN_W bits).
- IDLE:
  - Scan `m_awvalid` from `rr_ptr` upward, wrapping modulo N.
  - The first asserted master is registered into `grant`, and the FSM goes to ADDR.
  - No requests: stay in IDLE.
- ADDR:
  - `s_awvalid`, `s_awid`, `s_awaddr` and `s_awlen` are muxed from master `grant`.
  - `m_awready[grant]` = `s_awready`.
  - On the handshake (`s_awvalid & s_awready`): `beats` <= granted AWLEN, go to DATA.
- DATA:
  - `s_wvalid` and `s_wdata` are muxed from `grant`; `m_wready[grant]` = `s_wready`.
  - `s_wlast` = (`beats` == 0); it does not come from the master.
  - On each W handshake: if `beats` == 0, go to RESP; otherwise decrement `beats`.
  - On any W handshake where `m_wlast[grant]` differs from (`beats` == 0), pulse `wlast_err` for that cycle and continue using the counter.
- RESP:
  - `m_bvalid[grant]` = `s_bvalid`; `m_bid` = `s_bid`; `m_bresp` = `s_bresp`.
  - `s_bready` = `m_bready[grant]`.
  - On the handshake: `rr_ptr` <= (`grant`+1) mod N, go to IDLE.
- All ready/valid outputs to non-granted masters are 0 in every state.
- All slave-side valids, and `s_bready`, are 0 in IDLE and outside their own state.
- `m_bid` and `m_bresp` are 0 whenever no `m_bvalid` bit is high.
- A master that drops AWVALID between IDLE and ADDR keeps its grant; `s_awvalid` simply follows it low.
- Arithmetic: `beats` decrement never underflows, because the counter==0 beat exits DATA. The `rr_ptr` increment wraps explicitly for non-power-of-2 N.

## Timing
- Reset value (asynchronous, takes effect immediately when `reset` goes low):
  - state = IDLE; `grant`, `rr_ptr` and `beats` = 0.
  - Every output = 0, including `busy` and `wlast_err`.
- Reset asserted mid-transaction abandons the burst: no response is generated, and the first grant after release is searched from master 0.
- Grant latency: AWVALID sampled in IDLE at edge k means ADDR is active from k, so `s_awvalid` is visible in cycle k+1.
- All muxed valid/ready/data paths are combinational with zero added latency. `s_wlast`, `busy` and `grant` are registered state or decoded from it.
- Minimum transaction of AWLEN=0 with slaves always ready: IDLE, ADDR, DATA, RESP, IDLE = 4 cycles. The next grant can be taken at the edge that follows entry to IDLE.
- Simultaneous requests resolve in a single cycle by rotating priority; no master waits more than N-1 transactions.

## Test plan
- Single master: M0 writes AWLEN=3, data 0x11..0x44, slave ready 1 -> four `s_wdata` beats, `s_wlast` only on 0x44, `m_bvalid[0]` pulses with `s_bresp`; `busy` high for 7 cycles.
- Round-robin: all 4 masters request continuously, AWLEN=0 -> grant order 0,1,2,3,0; `rr_ptr` wraps from 3 to 0.
- Backpressure: `s_wready` toggles 1,0,0,1 during a 2-beat burst -> no data lost, `m_wready[grant]` mirrors `s_wready`, `beats` changes only on handshakes.
- WLAST mismatch: master asserts WLAST on beat 1 of AWLEN=2 -> `wlast_err` pulses once, third beat still accepted, `s_wlast` on beat 3 only.
- Response routing: `s_bid`=0x2A, `s_bresp`=2'b10 while M2 is granted, `m_bready[2]` held 0 for 3 cycles -> FSM stays in RESP, only `m_bvalid[2]` high, `m_bid`=0x2A.
- Reset mid-DATA: drive `reset` low during beat 2 -> all outputs 0 in the same cycle; after release, M0 and M3 both request -> M0 is granted.
